// File: rtl/qspi_flash_responder_pkg.sv
// Shared opcodes, status-register bit positions and FSM state type for the
// serial-flash responder.
package qspi_flash_responder_pkg;

    localparam logic [7:0] CMD_RDID    = 8'h9F;
    localparam logic [7:0] CMD_MIORDID = 8'hAF;
    localparam logic [7:0] CMD_RDSR    = 8'h05;
    localparam logic [7:0] CMD_RFSR    = 8'h70;
    localparam logic [7:0] CMD_RDVECR  = 8'h65;
    localparam logic [7:0] CMD_WRVECR  = 8'h61;
    localparam logic [7:0] CMD_WREN    = 8'h06;
    localparam logic [7:0] CMD_SE      = 8'hD8;
    localparam logic [7:0] CMD_BE      = 8'hC7;
    localparam logic [7:0] CMD_PP      = 8'h02;

    localparam int SR_WIP      = 0;
    localparam int SR_WEL      = 1;
    localparam int FSR_READY   = 7;
    localparam int VECR_QUAD_N = 7;

    // Bits clocked per frame; saturates once the MSB sets, which is beyond
    // every exact-length check the decoder needs.
    localparam int BIT_CNT_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    function automatic logic [7:0] sr_byte(input logic wel, input logic wip);
        sr_byte         = 8'h00;
        sr_byte[SR_WEL] = wel;
        sr_byte[SR_WIP] = wip;
    endfunction

    function automatic logic [7:0] fsr_byte(input logic wip);
        fsr_byte            = 8'h00;
        fsr_byte[FSR_READY] = ~wip;
    endfunction

endpackage

// File: rtl/qspi_flash_responder_shifter.sv
// Pin front end: synchronizes S/C/DQ into clk, detects C edges, shifts
// 1 or 4 bits per C rise in and drives 1 or 4 bits per C fall out.
module qspi_flash_responder_shifter
    import qspi_flash_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic                 sck,
    input  logic [3:0]           dq,
    input  logic                 quad,
    input  logic                 tx_en,
    input  logic [7:0]           tx_byte,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 rx_valid,
    output logic [7:0]           rx_byte,
    output logic [BIT_CNT_W-1:0] bit_count,
    output logic [3:0]           dq_drive,
    output logic [3:0]           dq_en
);

    logic [1:0] sel_sync;
    logic [1:0] sck_sync;
    logic       sel_prev;
    logic       sck_prev;
    logic [3:0] dq_meta;
    logic [3:0] dq_sync;
    logic [7:0] shreg;
    logic [2:0] phase;
    logic [7:0] shreg_next;
    logic [2:0] phase_next;
    logic       active;
    logic       sck_rise;
    logic       sck_fall;

    assign active      = ~sel_sync[1];
    assign sck_rise    =  sck_sync[1] & ~sck_prev;
    assign sck_fall    = ~sck_sync[1] &  sck_prev;
    assign frame_start = ~sel_sync[1] &  sel_prev;
    assign frame_end   =  sel_sync[1] & ~sel_prev;
    assign shreg_next  = quad ? {shreg[3:0], dq_sync} : {shreg[6:0], dq_sync[0]};
    assign phase_next  = phase + (quad ? 3'd4 : 3'd1);

    always_ff @(posedge clk) begin
        dq_meta <= dq;
        dq_sync <= dq_meta;
        if (active && sck_rise) begin
            shreg <= shreg_next;
            if (phase_next == 3'd0) begin
                rx_byte <= shreg_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_sync  <= 2'b11;
            sck_sync  <= 2'b00;
            sel_prev  <= 1'b1;
            sck_prev  <= 1'b0;
            phase     <= 3'd0;
            bit_count <= '0;
            rx_valid  <= 1'b0;
            dq_drive  <= 4'h0;
            dq_en     <= 4'h0;
        end else begin
            sel_sync <= {sel_sync[0], sel};
            sck_sync <= {sck_sync[0], sck};
            sel_prev <= sel_sync[1];
            sck_prev <= sck_sync[1];
            rx_valid <= 1'b0;
            if (frame_start) begin
                phase     <= 3'd0;
                bit_count <= '0;
            end else if (active && sck_rise) begin
                phase <= phase_next;
                if (!bit_count[BIT_CNT_W-1]) begin
                    bit_count <= bit_count + (quad ? BIT_CNT_W'(4) : BIT_CNT_W'(1));
                end
                rx_valid <= (phase_next == 3'd0);
            end
            // phase already counts the bits of the current byte, so it indexes the next bit out
            if (!active) begin
                dq_drive <= 4'h0;
                dq_en    <= 4'h0;
            end else if (sck_fall && tx_en) begin
                dq_en    <= quad ? 4'hF : 4'b0010;
                dq_drive <= quad ? (phase[2] ? tx_byte[3:0] : tx_byte[7:4])
                                 : {2'b00, tx_byte[3'd7 - phase], 1'b0};
            end
        end
    end

endmodule

// File: rtl/qspi_flash_responder.sv
// N25Q-style serial flash target: command decode, SR/FSR/VECR emulation,
// WEL/WIP flow with busy timer and program/erase requests to a backing store.
module qspi_flash_responder
    import qspi_flash_responder_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID  = 24'h20BA18,
    parameter logic [7:0]  VECR_INIT = 8'hDF,
    parameter int          PP_CYCLES = 64,
    parameter int          SE_CYCLES = 256,
    parameter int          BE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        S,
    input  logic        C,
    input  logic [3:0]  DQ_i,
    output logic [3:0]  DQ_o,
    output logic [3:0]  DQ_oe,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        erase_req,
    output logic        erase_all,
    output logic        busy
);

    localparam int TMAX    = (BE_CYCLES > SE_CYCLES) ? ((BE_CYCLES > PP_CYCLES) ? BE_CYCLES : PP_CYCLES)
                                                     : ((SE_CYCLES > PP_CYCLES) ? SE_CYCLES : PP_CYCLES);
    localparam int TIMER_W = $clog2(TMAX + 1);

    state_t                 state;
    state_t                 decode_state;
    logic [7:0]             cmd;
    logic [7:0]             sel_cmd;
    logic                   wel;
    logic                   wip;
    logic [7:0]             vecr;
    logic [7:0]             vecr_byte;
    logic                   vecr_got;
    logic [23:0]            addr;
    logic [1:0]             addr_cnt;
    logic [7:0]             offset;
    logic                   pp_any;
    logic [1:0]             id_idx;
    logic [1:0]             id_next;
    logic [7:0]             tx_byte;
    logic [7:0]             read_byte;
    logic [TIMER_W-1:0]     timer;
    logic                   quad;
    logic                   frame_start;
    logic                   frame_end;
    logic                   rx_valid;
    logic [7:0]             rx_byte;
    logic [BIT_CNT_W-1:0]   bit_count;

    assign quad    = ~vecr[VECR_QUAD_N];
    assign busy    = wip;
    assign sel_cmd = (state == ST_CMD) ? rx_byte : cmd;
    assign id_next = (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;

    qspi_flash_responder_shifter u_shifter (
        .clk         (clk),
        .reset       (reset),
        .sel         (S),
        .sck         (C),
        .dq          (DQ_i),
        .quad        (quad),
        .tx_en       (state == ST_RDATA),
        .tx_byte     (tx_byte),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .bit_count   (bit_count),
        .dq_drive    (DQ_o),
        .dq_en       (DQ_oe)
    );

    always_comb begin
        decode_state = ST_IGNORE;
        case (rx_byte)
            CMD_RDSR, CMD_RFSR:           decode_state = ST_RDATA;
            CMD_RDVECR:                   if (!wip) decode_state = ST_RDATA;
            CMD_RDID:                     if (!wip && !quad) decode_state = ST_RDATA;
            CMD_MIORDID:                  if (!wip && quad) decode_state = ST_RDATA;
            CMD_WREN, CMD_WRVECR, CMD_BE: if (!wip) decode_state = ST_WDATA;
            CMD_SE:                       if (!wip) decode_state = ST_ADDR;
            CMD_PP:                       if (!wip && wel) decode_state = ST_ADDR;
            default:                      decode_state = ST_IGNORE;
        endcase
    end

    // Status bytes are taken live at every byte boundary
    always_comb begin
        read_byte = 8'h00;
        case (sel_cmd)
            CMD_RDID, CMD_MIORDID: read_byte = (id_idx == 2'd0) ? JEDEC_ID[23:16] :
                                               (id_idx == 2'd1) ? JEDEC_ID[15:8] : JEDEC_ID[7:0];
            CMD_RDSR:              read_byte = sr_byte(wel, wip);
            CMD_RFSR:              read_byte = fsr_byte(wip);
            CMD_RDVECR:            read_byte = vecr;
            default:               read_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_valid && state == ST_ADDR) begin
            addr <= {addr[15:0], rx_byte};
        end
        if (rx_valid && state == ST_WDATA && cmd == CMD_WRVECR && !vecr_got) begin
            vecr_byte <= rx_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd       <= 8'h00;
            wel       <= 1'b0;
            wip       <= 1'b0;
            vecr      <= VECR_INIT;
            vecr_got  <= 1'b0;
            addr_cnt  <= 2'd0;
            offset    <= 8'h00;
            pp_any    <= 1'b0;
            id_idx    <= 2'd0;
            tx_byte   <= 8'h00;
            timer     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= 24'h0;
            mem_wdata <= 8'h00;
            erase_req <= 1'b0;
            erase_all <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            erase_req <= 1'b0;
            if (wip) begin
                timer <= timer - TIMER_W'(1);
                if (timer == TIMER_W'(1)) begin
                    wip <= 1'b0;
                    wel <= 1'b0;
                end
            end
            if (frame_start) begin
                state    <= ST_CMD;
                addr_cnt <= 2'd0;
                id_idx   <= 2'd0;
                pp_any   <= 1'b0;
                vecr_got <= 1'b0;
            end else if (frame_end) begin
                state <= ST_IDLE;
                // Only frames that reached WDATA can commit; partial frames fall through
                if (state == ST_WDATA) begin
                    case (cmd)
                        CMD_WREN: if (bit_count == BIT_CNT_W'(8)) wel <= 1'b1;
                        CMD_WRVECR: if (wel && bit_count >= BIT_CNT_W'(16)) begin
                            vecr <= vecr_byte;
                            wel  <= 1'b0;
                        end
                        CMD_SE: if (wel && bit_count == BIT_CNT_W'(32)) begin
                            erase_req <= 1'b1;
                            erase_all <= 1'b0;
                            mem_addr  <= addr;
                            wip       <= 1'b1;
                            wel       <= 1'b0;
                            timer     <= TIMER_W'(SE_CYCLES);
                        end
                        CMD_BE: if (wel && bit_count == BIT_CNT_W'(8)) begin
                            erase_req <= 1'b1;
                            erase_all <= 1'b1;
                            wip       <= 1'b1;
                            wel       <= 1'b0;
                            timer     <= TIMER_W'(BE_CYCLES);
                        end
                        CMD_PP: if (pp_any) begin
                            wip   <= 1'b1;
                            wel   <= 1'b0;
                            timer <= TIMER_W'(PP_CYCLES);
                        end
                        default: ;
                    endcase
                end
            end else if (rx_valid) begin
                case (state)
                    ST_CMD: begin
                        cmd     <= rx_byte;
                        state   <= decode_state;
                        tx_byte <= read_byte;
                        id_idx  <= id_next;
                    end
                    ST_ADDR: begin
                        addr_cnt <= addr_cnt + 2'd1;
                        if (addr_cnt == 2'd2) begin
                            state  <= ST_WDATA;
                            offset <= rx_byte;
                        end
                    end
                    ST_WDATA: begin
                        if (cmd == CMD_PP) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {addr[23:8], offset};
                            mem_wdata <= rx_byte;
                            offset    <= offset + 8'd1;
                            pp_any    <= 1'b1;
                        end else if (cmd == CMD_WRVECR) begin
                            vecr_got <= 1'b1;
                        end
                    end
                    ST_RDATA: begin
                        tx_byte <= read_byte;
                        id_idx  <= id_next;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: a host model bit-bangs S/C/DQ in
// extended-SPI and quad modes and checks reads, commits and memory requests.
module tb_qspi_flash_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        S;
    logic        C;
    logic [3:0]  DQ_i;
    logic [3:0]  DQ_o;
    logic [3:0]  DQ_oe;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        erase_req;
    logic        erase_all;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit quad_mode = 1'b0;

    logic [7:0]  rxb [7];
    logic [3:0]  oeb [7];
    logic [23:0] we_addr [$];
    logic [7:0]  we_data [$];
    int          er_cnt = 0;
    int          overlap_cnt = 0;
    logic [23:0] er_addr;
    logic        er_all;

    always #5 clk = ~clk;

    qspi_flash_responder #(
        .PP_CYCLES(400),
        .SE_CYCLES(400),
        .BE_CYCLES(800)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .S         (S),
        .C         (C),
        .DQ_i      (DQ_i),
        .DQ_o      (DQ_o),
        .DQ_oe     (DQ_oe),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .erase_req (erase_req),
        .erase_all (erase_all),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_addr.push_back(mem_addr);
            we_data.push_back(mem_wdata);
        end
        if (erase_req === 1'b1) begin
            er_cnt  = er_cnt + 1;
            er_addr = mem_addr;
            er_all  = erase_all;
        end
        if (mem_we === 1'b1 && erase_req === 1'b1) overlap_cnt = overlap_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic [3:0] oe);
        rx = 8'h00;
        oe = 4'h0;
        if (!quad_mode) begin
            for (int i = 7; i >= 0; i--) begin
                DQ_i = {3'b000, tx[i]};
                wait_clk(HALF);
                rx[i] = DQ_o[1];
                oe    = DQ_oe;
                C = 1'b1;
                wait_clk(HALF);
                C = 1'b0;
            end
        end else begin
            for (int i = 1; i >= 0; i--) begin
                DQ_i = tx[i*4 +: 4];
                wait_clk(HALF);
                rx[i*4 +: 4] = DQ_o;
                oe           = DQ_oe;
                C = 1'b1;
                wait_clk(HALF);
                C = 1'b0;
            end
        end
    endtask

    task automatic frame(input int n, input logic [7:0] b0,
                         input logic [7:0] b1 = 8'h00, input logic [7:0] b2 = 8'h00,
                         input logic [7:0] b3 = 8'h00, input logic [7:0] b4 = 8'h00,
                         input logic [7:0] b5 = 8'h00, input logic [7:0] b6 = 8'h00);
        logic [7:0] tx [7];
        tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3;
        tx[4] = b4; tx[5] = b5; tx[6] = b6;
        for (int i = 0; i < 7; i++) begin
            rxb[i] = 8'h00;
            oeb[i] = 4'h0;
        end
        S = 1'b0;
        wait_clk(4);
        for (int i = 0; i < n; i++) xfer(tx[i], rxb[i], oeb[i]);
        wait_clk(HALF);
        S = 1'b1;
        wait_clk(8);
    endtask

    task automatic wait_not_busy();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            wait_clk(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_release: got %b expected 0 within 2000 clk", busy); end
    endtask

    task automatic test_reset();
        reset = 1'b1; S = 1'b1; C = 1'b0; DQ_i = 4'h0;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(5);
        checks++;
        if ({DQ_o, DQ_oe} !== 8'h00) begin errors++; $display("FAIL reset_dq: got %h expected 00", {DQ_o, DQ_oe}); end
        checks++;
        if ({mem_we, erase_req, erase_all, busy} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_we, erase_req, erase_all, busy}); end
        checks++;
        if ({mem_addr, mem_wdata} !== 32'h0) begin errors++; $display("FAIL reset_mem: got %h expected 00000000", {mem_addr, mem_wdata}); end
        frame(2, 8'h05);
        checks++;
        if (rxb[1] !== 8'h00) begin errors++; $display("FAIL reset_sr: got %h expected 00", rxb[1]); end
        frame(2, 8'h70);
        checks++;
        if (rxb[1] !== 8'h80) begin errors++; $display("FAIL reset_fsr: got %h expected 80", rxb[1]); end
        frame(2, 8'h65);
        checks++;
        if (rxb[1] !== 8'hDF) begin errors++; $display("FAIL reset_vecr: got %h expected DF", rxb[1]); end
    endtask

    task automatic test_rdid();
        logic [7:0] exp_id [4];
        exp_id[0] = 8'h20; exp_id[1] = 8'hBA; exp_id[2] = 8'h18; exp_id[3] = 8'h20;
        frame(5, 8'h9F);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxb[i+1] !== exp_id[i]) begin errors++; $display("FAIL rdid_byte%0d: got %h expected %h", i, rxb[i+1], exp_id[i]); end
        end
        checks++;
        if (oeb[1] !== 4'b0010) begin errors++; $display("FAIL rdid_oe: got %b expected 0010", oeb[1]); end
        checks++;
        if (DQ_oe !== 4'b0000) begin errors++; $display("FAIL rdid_oe_release: got %b expected 0000", DQ_oe); end
        frame(3, 8'hAB);
        checks++;
        if ({oeb[1], oeb[2]} !== 8'h00) begin errors++; $display("FAIL unknown_oe: got %h expected 00", {oeb[1], oeb[2]}); end
    endtask

    task automatic test_vecr();
        frame(2, 8'h61, 8'h5F);
        frame(2, 8'h65);
        checks++;
        if (rxb[1] !== 8'hDF) begin errors++; $display("FAIL wrvecr_no_wel: got %h expected DF", rxb[1]); end
        frame(1, 8'h06);
        frame(2, 8'h61, 8'h5F);
        quad_mode = 1'b1;
        frame(2, 8'h65);
        checks++;
        if (rxb[1] !== 8'h5F) begin errors++; $display("FAIL vecr_quad: got %h expected 5F", rxb[1]); end
        checks++;
        if (oeb[1] !== 4'hF) begin errors++; $display("FAIL quad_oe: got %b expected 1111", oeb[1]); end
        frame(2, 8'hAF);
        checks++;
        if (rxb[1] !== 8'h20) begin errors++; $display("FAIL miordid_quad: got %h expected 20", rxb[1]); end
        frame(2, 8'h05);
        checks++;
        if (rxb[1] !== 8'h00) begin errors++; $display("FAIL sr_after_wrvecr: got %h expected 00", rxb[1]); end
        frame(2, 8'h9F);
        checks++;
        if (oeb[1] !== 4'h0) begin errors++; $display("FAIL rdid_in_quad_oe: got %b expected 0000", oeb[1]); end
        frame(1, 8'h06);
        frame(2, 8'h61, 8'hDF);
        quad_mode = 1'b0;
        frame(2, 8'h65);
        checks++;
        if (rxb[1] !== 8'hDF) begin errors++; $display("FAIL vecr_restore: got %h expected DF", rxb[1]); end
    endtask

    task automatic test_pp();
        we_addr.delete();
        we_data.delete();
        frame(1, 8'h06);
        frame(7, 8'h02, 8'h00, 8'h01, 8'hFE, 8'hAA, 8'hBB, 8'hCC);
        checks++;
        if (we_addr.size() != 3) begin errors++; $display("FAIL pp_count: got %0d expected 3", we_addr.size()); end
        while (we_addr.size() < 3) begin we_addr.push_back('x); we_data.push_back('x); end
        checks++;
        if ({we_addr[0], we_addr[1], we_addr[2]} !== {24'h0001FE, 24'h0001FF, 24'h000100})
            begin errors++; $display("FAIL pp_addr: got %h %h %h expected 0001fe 0001ff 000100", we_addr[0], we_addr[1], we_addr[2]); end
        checks++;
        if ({we_data[0], we_data[1], we_data[2]} !== 24'hAABBCC)
            begin errors++; $display("FAIL pp_data: got %h %h %h expected aa bb cc", we_data[0], we_data[1], we_data[2]); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL pp_busy: got %b expected 1", busy); end
        frame(2, 8'h05);
        checks++;
        if (rxb[1] !== 8'h01) begin errors++; $display("FAIL pp_sr_busy: got %h expected 01", rxb[1]); end
        wait_not_busy();
        frame(2, 8'h70);
        checks++;
        if (rxb[1] !== 8'h80) begin errors++; $display("FAIL pp_fsr_done: got %h expected 80", rxb[1]); end
        frame(2, 8'h05);
        checks++;
        if (rxb[1] !== 8'h00) begin errors++; $display("FAIL pp_sr_done: got %h expected 00", rxb[1]); end
    endtask

    task automatic test_se();
        int base;
        base = er_cnt;
        frame(1, 8'h06);
        frame(4, 8'hD8, 8'h03, 8'h00, 8'h00);
        checks++;
        if (er_cnt != base + 1) begin errors++; $display("FAIL se_count: got %0d expected %0d", er_cnt, base + 1); end
        checks++;
        if ({er_all, er_addr} !== {1'b0, 24'h030000}) begin errors++; $display("FAIL se_req: got %b %h expected 0 030000", er_all, er_addr); end
        frame(1, 8'h06);
        frame(2, 8'h05);
        checks++;
        if (rxb[1] !== 8'h01) begin errors++; $display("FAIL wren_during_wip: got %h expected 01", rxb[1]); end
        wait_not_busy();
        frame(1, 8'h06);
        frame(3, 8'hD8, 8'h03, 8'h00);
        checks++;
        if (er_cnt != base + 1) begin errors++; $display("FAIL se_partial: got %0d expected %0d", er_cnt, base + 1); end
        frame(2, 8'h05);
        checks++;
        if (rxb[1] !== 8'h02) begin errors++; $display("FAIL se_partial_sr: got %h expected 02", rxb[1]); end
    endtask

    task automatic test_be_reset();
        int base;
        base = er_cnt;
        frame(1, 8'h06);
        frame(1, 8'hC7);
        checks++;
        if (er_cnt != base + 1 || er_all !== 1'b1) begin errors++; $display("FAIL be_req: got %0d %b expected %0d 1", er_cnt, er_all, base + 1); end
        wait_clk(380);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL be_busy_mid: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, DQ_oe} !== 5'b0) begin errors++; $display("FAIL be_reset_now: got %b expected 00000", {busy, DQ_oe}); end
        wait_clk(3);
        reset = 1'b0;
        wait_clk(5);
        frame(2, 8'h05);
        checks++;
        if (rxb[1] !== 8'h00) begin errors++; $display("FAIL be_reset_sr: got %h expected 00", rxb[1]); end
        frame(2, 8'h65);
        checks++;
        if (rxb[1] !== 8'hDF) begin errors++; $display("FAIL be_reset_vecr: got %h expected DF", rxb[1]); end
        checks++;
        if (overlap_cnt != 0) begin errors++; $display("FAIL we_erase_overlap: got %0d expected 0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_rdid();
        test_vecr();
        test_pp();
        test_se();
        test_be_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
